rv32i_trace_buffer: RTL
=======================

Name: rv32i_trace_buffer

Overview:
- Parametrised on-chip trace capture unit for the rv32i_cpu debug interface.
- Records per-cycle {pc, instruction, stall, flush, cycle stamp} into a DEPTH-entry buffer after a programmable trigger.
- Stops on buffer full, a cycle budget, or a manual stop, then drains the buffer oldest-first over a valid/ready port.
- Replaces the per-cycle display and fixed cycle limit used in CPU benches; also synthesisable for on-board debug.

Parameters:
- XLEN, 32, width of pc and instruction fields.
- DEPTH, 32, trace entries; power of 2, ≥2.
- CNT_W, 32, width of the cycle counter and stamp.
- REC_STALLS, 1, 1 = record stalled cycles; 0 = skip cycles with in_stall=1 (counter still advances).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  start request; honoured only in IDLE.
- stop  in  1  manual stop; the stop cycle is not recorded.
- mode  in  1  0 = stop when full; 1 = circular, keeps the newest DEPTH entries. Sampled on arm.
- trig_en  in  1  1 = wait for pc match; 0 = trigger immediately. Sampled on arm.
- trig_pc  in  XLEN  trigger pc. Sampled on arm.
- max_cycles  in  CNT_W  cycle budget; 0 = unlimited. Sampled on arm.
- in_pc  in  XLEN  CPU debug_pc.
- in_instr  in  XLEN  CPU debug_instruction.
- in_stall  in  1  CPU debug_stall.
- in_flush  in  1  CPU debug_flush.
- out_valid  out  1  buffer entry available.
- out_ready  in  1  consumer accepts the entry.
- out_pc  out  XLEN  entry pc.
- out_instr  out  XLEN  entry instruction.
- out_stall  out  1  entry stall flag.
- out_flush  out  1  entry flush flag.
- out_stamp  out  CNT_W  cycles since trigger; the trigger cycle is 0.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  circular mode discarded at least one entry.
- busy  out  1  state is ARMED or CAPTURE.
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3.

Behaviour:
- Reset, synchronous, any state: state=IDLE; count=0; wr_ptr=rd_ptr=0; cycle counter=0; overflow=0; out_valid=0; busy=0. Memory contents are not cleared. The out_* data fields are don't-care while out_valid=0.
- IDLE: arm=1 latches mode, trig_en, trig_pc and max_cycles; clears count, pointers and overflow; next state ARMED.
- ARMED:
  - stop=1 → IDLE, nothing written. Stop beats a same-cycle trigger.
  - Trigger condition = !trig_en || in_pc==trig_pc.
  - On trigger, that cycle's sample is written with stamp 0, counter←1, next state CAPTURE.
  - The trigger sample is written even when REC_STALLS=0.
- CAPTURE, each cycle evaluated in priority order:
  1. stop=1 → DRAIN, no write.
  2. Otherwise write the sample if (REC_STALLS || !in_stall); stamp = counter; counter increments every cycle regardless of whether a write occurs.
  3. mode=0: the write that makes count==DEPTH → DRAIN.
  4. max_cycles≠0 and counter+1==max_cycles → DRAIN after this cycle's write.
- Circular mode (mode=1): when full, a write overwrites the oldest entry; rd_ptr advances with wr_ptr; count stays at DEPTH; overflow←1 (sticky until next arm or reset).
- Pointers wrap modulo DEPTH.
- DRAIN:
  - out_valid = (count≠0). Read is first-word-fall-through: out_* = mem[rd_ptr] combinationally.
  - Each out_valid&&out_ready pops one entry: rd_ptr+1, count−1.
  - out_valid first rises the cycle after the last capture write.
  - When count reaches 0 (including entry with count=0) → IDLE on the next edge.
  - arm and stop are ignored in DRAIN.
- Data must not be lost or duplicated under any out_ready pattern.
- busy is registered along with the state.

Decomposition:
- Shared package rv_debug_pkg:
  - state encodings (IDLE..DRAIN);
  - record field offsets and REC_W = 2*XLEN+2+CNT_W.
- One sub-module, trace_ram:
  - DEPTH×REC_W;
  - one synchronous write port, one asynchronous read port.
- The FSM, pointers and counter stay in rv32i_trace_buffer.

Test Plan (DEPTH=8, in_pc advancing 0,4,8,… one step per cycle):
1. mode=0, trig_en=0, max_cycles=0, arm → 8 entries captured, pc 0x00..0x1C with stamps 0..7; state→DRAIN; with out_ready=1, the 8 entries drain in 8 cycles, then IDLE.
2. mode=1, max_cycles=20 → 20 cycles run; drained stamps 12..19 (pc 0x30..0x4C); overflow=1; count=8 at DRAIN entry.
3. trig_en=1, trig_pc=0x10, mode=0 → ARMED holds for 4 cycles; first entry pc=0x10 with stamp 0; last entry pc=0x2C with stamp 7.
4. REC_STALLS=0, in_stall=1 on the 2nd and 3rd cycles after trigger → recorded stamps 0,3,4,5,6,7,8,9.
5. out_ready pattern 1,0,0,1,1,0,1,… during DRAIN → exactly 8 handshakes with stamps strictly ascending; count decrements only on handshake.
6. Three boundary cases:
   - reset asserted after 3 CAPTURE writes → next cycle state=IDLE, count=0, out_valid=0, busy=0;
   - separately, stop and trigger in the same ARMED cycle → IDLE, count=0;
   - separately, stop in the 5th CAPTURE cycle → DRAIN with count=5.

Source files
------------

// File: rtl/rv_debug_pkg.sv
// Shared definitions for the rv32i debug trace path: FSM state encodings and
// the layout of one trace record as stored in the trace RAM.
package rv_debug_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } trace_state_t;

   // Record layout, MSB to LSB: {pc, instruction, stall, flush, stamp}
   function automatic int rec_w(input int xlen, input int cnt_w);
      return 2 * xlen + 2 + cnt_w;
   endfunction

   function automatic int stamp_lsb();
      return 0;
   endfunction

   function automatic int flush_bit(input int cnt_w);
      return cnt_w;
   endfunction

   function automatic int stall_bit(input int cnt_w);
      return cnt_w + 1;
   endfunction

   function automatic int instr_lsb(input int cnt_w);
      return cnt_w + 2;
   endfunction

   function automatic int pc_lsb(input int xlen, input int cnt_w);
      return xlen + cnt_w + 2;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port so the
// drain side can present the oldest entry in the same cycle (fall-through).
module trace_ram #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 98
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write one record per enabled cycle; contents are never cleared
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rv32i_trace_buffer.sv
// Trace capture unit: waits for a trigger, records per-cycle CPU debug samples
// into a ring buffer, stops on full / cycle budget / manual stop, then drains
// the buffer oldest-first over a valid/ready port.
module rv32i_trace_buffer
   import rv_debug_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 32,
   parameter int CNT_W      = 32,
   parameter int REC_STALLS = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       arm,
   input  logic                       stop,
   input  logic                       mode,
   input  logic                       trig_en,
   input  logic [XLEN-1:0]            trig_pc,
   input  logic [CNT_W-1:0]           max_cycles,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [XLEN-1:0]            in_instr,
   input  logic                       in_stall,
   input  logic                       in_flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_instr,
   output logic                       out_stall,
   output logic                       out_flush,
   output logic [CNT_W-1:0]           out_stamp,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       busy,
   output logic [1:0]                 state
);

   localparam int AW        = $clog2(DEPTH);
   localparam int CW        = AW + 1;
   localparam int REC_W     = rec_w(XLEN, CNT_W);
   localparam int STAMP_LSB = stamp_lsb();
   localparam int FLUSH_BIT = flush_bit(CNT_W);
   localparam int STALL_BIT = stall_bit(CNT_W);
   localparam int INSTR_LSB = instr_lsb(CNT_W);
   localparam int PC_LSB    = pc_lsb(XLEN, CNT_W);

   trace_state_t      state_q, state_d;
   logic              mode_q, trig_en_q;
   logic [XLEN-1:0]   trig_pc_q;
   logic [CNT_W-1:0]  max_cycles_q;
   logic [CNT_W-1:0]  cycle_q, cycle_d, wr_stamp;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_q;
   logic              overflow_q, busy_q;
   logic              wr_en, pop, clear, trigger, full;
   logic [REC_W-1:0]  wr_data, rd_data;

   assign trigger   = !trig_en_q || (in_pc == trig_pc_q);
   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = (state_q == ST_DRAIN) && (count_q != '0);

   // Next-state, write-enable and stamp selection for the capture FSM
   always_comb begin
      state_d  = state_q;
      cycle_d  = cycle_q;
      wr_en    = 1'b0;
      wr_stamp = cycle_q;
      pop      = 1'b0;
      clear    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               clear   = 1'b1;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (trigger) begin
               wr_en    = 1'b1;
               wr_stamp = '0;
               cycle_d  = CNT_W'(1);
               state_d  = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (stop) begin
               state_d = ST_DRAIN;
            end else begin
               wr_en   = (REC_STALLS != 0) || !in_stall;
               cycle_d = cycle_q + 1'b1;
               if (!mode_q && wr_en && (count_q == CW'(DEPTH - 1))) begin
                  state_d = ST_DRAIN;
               end
               if ((max_cycles_q != '0) && (cycle_d == max_cycles_q)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            pop = out_valid && out_ready;
            if (count_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, pointers, occupancy and cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cycle_q    <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         busy_q  <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
         if (clear) begin
            count_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full) begin
               rd_ptr     <= rd_ptr + 1'b1;
               overflow_q <= 1'b1;
            end else begin
               count_q <= count_q + 1'b1;
            end
         end else if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Capture configuration is frozen at arm time
   always_ff @(posedge clk) begin
      if (clear) begin
         mode_q       <= mode;
         trig_en_q    <= trig_en;
         trig_pc_q    <= trig_pc;
         max_cycles_q <= max_cycles;
      end
   end

   assign wr_data = {in_pc, in_instr, in_stall, in_flush, wr_stamp};

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   assign out_pc    = rd_data[PC_LSB +: XLEN];
   assign out_instr = rd_data[INSTR_LSB +: XLEN];
   assign out_stall = rd_data[STALL_BIT];
   assign out_flush = rd_data[FLUSH_BIT];
   assign out_stamp = rd_data[STAMP_LSB +: CNT_W];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign busy      = busy_q;
   assign state     = state_q;

endmodule
